doodle_jump_ctrl: RTL and testbench

//  Parametrised vertical-motion controller for the doodle: rise/fall/landing FSM stepped once per frame Tick.

---
 rtl/doodle_pkg.sv | 25 ++
 rtl/doodle_plat_hit.sv | 47 ++++
 rtl/doodle_jump_ctrl.sv | 154 +++++++++++++++
 tb/tb_doodle_jump_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared state encoding, default widths and helpers for the doodle motion controller.
package doodle_pkg;

  // One-hot states so q_* outputs are direct register bits
  typedef enum logic [3:0] {
    S_I    = 4'b0001,
    S_UP   = 4'b0010,
    S_DOWN = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  localparam int DEF_X_W     = 10;
  localparam int DEF_Y_W     = 10;
  localparam int DEF_SCORE_W = 16;
  localparam int DEF_N_PLAT  = 8;

  // Ceiling log2, never below 1 so index ports always have a bit
  function automatic int doodle_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/doodle_plat_hit.sv
// Landing test: per-channel downward crossing + horizontal overlap, lowest channel wins.
module doodle_plat_hit
  import doodle_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int N_PLAT   = DEF_N_PLAT,
  parameter int DOODLE_W = 32,
  parameter int PLAT_W   = 64,
  parameter int IDX_W    = doodle_clog2(N_PLAT)
) (
  input  logic [X_W-1:0]        i_doodle_x,
  input  logic [Y_W-1:0]        i_doodle_y,
  input  logic [Y_W:0]          i_ny,
  input  logic [N_PLAT*X_W-1:0] i_plat_x,
  input  logic [N_PLAT*Y_W-1:0] i_plat_y,
  input  logic [N_PLAT-1:0]     i_plat_valid,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_hit_idx,
  output logic [Y_W-1:0]        o_hit_y
);

  logic [X_W:0] w_dx_right;
  assign w_dx_right = {1'b0, i_doodle_x} + (X_W+1)'(DOODLE_W);

  // Scan high to low so the lowest hitting channel is the last write
  always_comb begin
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    o_hit     = 1'b0;
    o_hit_idx = '0;
    o_hit_y   = '0;
    for (int i = N_PLAT - 1; i >= 0; i--) begin
      px = i_plat_x[i*X_W +: X_W];
      py = i_plat_y[i*Y_W +: Y_W];
      if (i_plat_valid[i] &&
          (i_doodle_y < py) && ({1'b0, py} <= i_ny) &&
          (w_dx_right > {1'b0, px}) &&
          ({1'b0, i_doodle_x} < ({1'b0, px} + (X_W+1)'(PLAT_W)))) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
        o_hit_y   = py;
      end
    end
  end

endmodule

// File: rtl/doodle_jump_ctrl.sv
// Doodle vertical-motion controller: rise/fall/land FSM stepped per frame Tick,
// camera scroll above the middle line, saturating score from scrolled pixels.
// Optional DOODLE_SPRING_EN adds plat_spring: a spring landing doubles the next rise.
module doodle_jump_ctrl
  import doodle_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int N_PLAT      = DEF_N_PLAT,
  parameter int JUMP_HEIGHT = 120,
  parameter int STEP        = 2,
  parameter int V_RES       = 480,
  parameter int V_MIDDLE    = 240,
  parameter int START_Y     = 400,
  parameter int DOODLE_W    = 32,
  parameter int PLAT_W      = 64
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              Tick,
  input  logic                              Start,
  input  logic                              Ack,
  input  logic [X_W-1:0]                    doodle_x,
  input  logic [N_PLAT*X_W-1:0]             plat_x,
  input  logic [N_PLAT*Y_W-1:0]             plat_y,
  input  logic [N_PLAT-1:0]                 plat_valid,
`ifdef DOODLE_SPRING_EN
  input  logic [N_PLAT-1:0]                 plat_spring,
`endif
  output logic [Y_W-1:0]                    doodle_y,
  output logic                              scroll,
  output logic [Y_W-1:0]                    scroll_amt,
  output logic [SCORE_W-1:0]                score,
  output logic [doodle_clog2(N_PLAT)-1:0]   landed_idx,
  output logic                              q_I,
  output logic                              q_Up,
  output logic                              q_Down,
  output logic                              q_Done
);

  localparam int IDX_W  = doodle_clog2(N_PLAT);
  // Wide enough for a doubled (spring) rise target
  localparam int RISE_W = doodle_clog2(2*JUMP_HEIGHT + 2*STEP + 1) + 1;

  state_t              r_state;
  logic [Y_W-1:0]      r_y;
  logic [RISE_W-1:0]   r_rise;
  logic [RISE_W-1:0]   r_target;
  logic [SCORE_W-1:0]  r_score;
  logic                r_scroll;
  logic [Y_W-1:0]      r_amt;
  logic [IDX_W-1:0]    r_idx;

  logic [Y_W:0]        w_ny;
  logic [RISE_W-1:0]   w_rise_nxt;
  logic [SCORE_W:0]    w_score_sum;
  logic [SCORE_W-1:0]  w_score_sat;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic [Y_W-1:0]      w_hit_y;
  logic [RISE_W-1:0]   w_land_target;

  assign w_ny        = {1'b0, r_y} + (Y_W+1)'(STEP);
  assign w_rise_nxt  = r_rise + RISE_W'(STEP);
  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(STEP);
  assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

`ifdef DOODLE_SPRING_EN
  assign w_land_target = plat_spring[w_hit_idx] ? RISE_W'(2*JUMP_HEIGHT) : RISE_W'(JUMP_HEIGHT);
`else
  assign w_land_target = RISE_W'(JUMP_HEIGHT);
`endif

  doodle_plat_hit #(
    .X_W(X_W), .Y_W(Y_W), .N_PLAT(N_PLAT),
    .DOODLE_W(DOODLE_W), .PLAT_W(PLAT_W), .IDX_W(IDX_W)
  ) u_hit (
    .i_doodle_x  (doodle_x),
    .i_doodle_y  (r_y),
    .i_ny        (w_ny),
    .i_plat_x    (plat_x),
    .i_plat_y    (plat_y),
    .i_plat_valid(plat_valid),
    .o_hit       (w_hit),
    .o_hit_idx   (w_hit_idx),
    .o_hit_y     (w_hit_y)
  );

  // Motion FSM; all outputs come straight from these registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_I;
      r_y      <= Y_W'(START_Y);
      r_rise   <= '0;
      r_target <= RISE_W'(JUMP_HEIGHT);
      r_score  <= '0;
      r_scroll <= 1'b0;
      r_amt    <= '0;
      r_idx    <= '0;
    end else begin
      r_scroll <= 1'b0;
      case (r_state)
        S_I: if (Start) begin
          r_state  <= S_UP;
          r_y      <= Y_W'(START_Y);
          r_rise   <= '0;
          r_target <= RISE_W'(JUMP_HEIGHT);
          r_score  <= '0;
        end
        S_UP: if (Tick) begin
          // y-STEP < V_MIDDLE written without the subtraction to avoid underflow
          if ({1'b0, r_y} < (Y_W+1)'(V_MIDDLE + STEP)) begin
            r_scroll <= 1'b1;
            r_amt    <= Y_W'(STEP);
            r_score  <= w_score_sat;
          end else begin
            r_y <= r_y - Y_W'(STEP);
          end
          r_rise <= w_rise_nxt;
          // Turn over when another step would reach the target
          if (w_rise_nxt + RISE_W'(STEP) >= r_target) r_state <= S_DOWN;
        end
        S_DOWN: if (Tick) begin
          if (w_hit) begin
            r_y      <= w_hit_y;
            r_idx    <= w_hit_idx;
            r_rise   <= '0;
            r_target <= w_land_target;
            r_state  <= S_UP;
          end else if (w_ny >= (Y_W+1)'(V_RES - 1)) begin
            r_y     <= Y_W'(V_RES - 1);
            r_state <= S_DONE;
          end else begin
            r_y <= w_ny[Y_W-1:0];
          end
        end
        S_DONE: if (Ack) r_state <= S_I;
        default: r_state <= S_I;
      endcase
    end
  end

  assign doodle_y   = r_y;
  assign scroll     = r_scroll;
  assign scroll_amt = r_amt;
  assign score      = r_score;
  assign landed_idx = r_idx;
  assign q_I        = r_state[0];
  assign q_Up       = r_state[1];
  assign q_Down     = r_state[2];
  assign q_Done     = r_state[3];

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Directed bench for doodle_jump_ctrl with default parameters.
module tb_doodle_jump_ctrl;

  localparam int X_W = 10, Y_W = 10, SCORE_W = 16, N_PLAT = 8;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic                  Tick, Start, Ack;
  logic [X_W-1:0]        doodle_x;
  logic [N_PLAT*X_W-1:0] plat_x;
  logic [N_PLAT*Y_W-1:0] plat_y;
  logic [N_PLAT-1:0]     plat_valid;
  logic [Y_W-1:0]        doodle_y;
  logic                  scroll;
  logic [Y_W-1:0]        scroll_amt;
  logic [SCORE_W-1:0]    score;
  logic [2:0]            landed_idx;
  logic                  q_I, q_Up, q_Down, q_Done;

  int checks = 0;
  int errors = 0;

  doodle_jump_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .Start(Start), .Ack(Ack),
    .doodle_x(doodle_x), .plat_x(plat_x), .plat_y(plat_y), .plat_valid(plat_valid),
    .doodle_y(doodle_y), .scroll(scroll), .scroll_amt(scroll_amt), .score(score),
    .landed_idx(landed_idx), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle Tick; returns at the following negedge with outputs updated
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk) Tick = 1'b1;
      @(negedge Clk) Tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge Clk) Ack = 1'b1;
    @(negedge Clk) Ack = 1'b0;
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    chk(tag, {q_Done, q_Down, q_Up, q_I}, exp);
  endtask

  initial begin
    Reset_n = 1'b0; Tick = 0; Start = 0; Ack = 0;
    doodle_x = 10'd200; plat_x = '0; plat_y = '0; plat_valid = '0;
    #12;
    st("rst_state", 4'b0001);
    chk("rst_y", doodle_y, 400);
    chk("rst_score", score, 0);
    chk("rst_scroll", scroll, 0);
    chk("rst_amt", scroll_amt, 0);
    chk("rst_idx", landed_idx, 0);
    @(negedge Clk) Reset_n = 1'b1;

    // Tick in I is ignored
    tick(1);
    chk("i_tick_y", doodle_y, 400);
    st("i_tick_state", 4'b0001);

    // Plain jump: 59 rising Ticks to 282, turn over, then fall
    pulse_start();
    st("start_up", 4'b0010);
    tick(58);
    chk("rise58_y", doodle_y, 284);
    st("rise58_up", 4'b0010);
    tick(1);
    chk("rise59_y", doodle_y, 282);
    st("rise59_down", 4'b0100);
    chk("rise_noscroll", score, 0);
    tick(1);
    chk("fall1_y", doodle_y, 284);
    tick(8);
    chk("fall_y300", doodle_y, 300);

    // Platform 0 at y=305 directly under the doodle: land on third Tick
    plat_valid[0] = 1'b1; plat_x[0 +: 10] = 10'd200; plat_y[0 +: 10] = 10'd305;
    tick(2);
    chk("pre_land_y", doodle_y, 304);
    st("pre_land_down", 4'b0100);
    tick(1);
    chk("land0_y", doodle_y, 305);
    chk("land0_idx", landed_idx, 0);
    st("land0_up", 4'b0010);
    plat_valid = '0;

    // Fresh jump for a multi-channel landing
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    pulse_start();
    tick(59 + 10);
    chk("pre_multi_y", doodle_y, 302);
    // ch1 crosses but sits exactly right of the sprite (no overlap)
    plat_x[1*10 +: 10] = 10'd232; plat_y[1*10 +: 10] = 10'd303;
    // ch2 overlaps by a single pixel on the left
    plat_x[2*10 +: 10] = 10'd137; plat_y[2*10 +: 10] = 10'd303;
    plat_x[5*10 +: 10] = 10'd200; plat_y[5*10 +: 10] = 10'd304;
    plat_valid = 8'b0010_0110;
    tick(1);
    chk("multi_y", doodle_y, 303);
    chk("multi_idx", landed_idx, 2);
    st("multi_up", 4'b0010);
    plat_valid = '0;

    // Rise from 303: 31 Ticks reach 241, then the camera scrolls
    tick(31);
    chk("mid_y", doodle_y, 241);
    chk("mid_scroll", scroll, 0);
    chk("mid_score", score, 0);
    tick(1);
    chk("scr_flag", scroll, 1);
    chk("scr_amt", scroll_amt, 2);
    chk("scr_score", score, 2);
    chk("scr_y", doodle_y, 241);
    @(negedge Clk);
    chk("scr_pulse_end", scroll, 0);
    tick(1);
    chk("scr2_score", score, 4);
    tick(26);
    chk("scr_total", score, 56);
    st("scr_to_down", 4'b0100);
    tick(1);
    chk("scr_fall_y", doodle_y, 243);
    chk("fall_noscroll", scroll, 0);

    // Asynchronous reset mid-fall, checked before any clock edge
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    st("arst_state", 4'b0001);
    chk("arst_score", score, 0);
    chk("arst_y", doodle_y, 400);
    chk("arst_idx", landed_idx, 0);
    @(negedge Clk) Reset_n = 1'b1;

    // Fall to the floor with no platforms
    pulse_start();
    tick(59 + 98);
    chk("prefloor_y", doodle_y, 478);
    st("prefloor_down", 4'b0100);
    tick(1);
    chk("floor_y", doodle_y, 479);
    st("floor_done", 4'b1000);
    pulse_start();
    tick(1);
    st("done_ignores", 4'b1000);
    chk("done_y", doodle_y, 479);
    pulse_ack();
    st("ack_idle", 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
